// File: rtl/cv32e40p_rvfi_retire_buf.sv
// rtl/cv32e40p_rvfi_retire_buf.sv - RVFI retirement tracker: per-stage shadow records plus an ordered output FIFO
// Records follow the core's pipeline via adv_i/kill_i and are stamped with a retirement order on exit.
module cv32e40p_rvfi_retire_buf #(
  parameter int NSTAGES = 3,
  parameter int DEPTH   = 4,
  parameter int INFO_W  = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       in_valid_i,
  input  logic [31:0]                in_insn_i,
  input  logic [31:0]                in_pc_rdata_i,
  input  logic [4:0]                 in_rd_addr_i,
  input  logic [INFO_W-1:0]          in_info_i,
  input  logic [NSTAGES-1:0]         adv_i,
  input  logic [NSTAGES-1:0]         kill_i,
  input  logic [31:0]                rd_wdata_i,
  input  logic                       rvfi_ready_i,
  output logic                       rvfi_valid,
  output logic [63:0]                rvfi_order,
  output logic [31:0]                rvfi_insn,
  output logic [31:0]                rvfi_pc_rdata,
  output logic [4:0]                 rvfi_rd_addr,
  output logic [31:0]                rvfi_rd_wdata,
  output logic [INFO_W-1:0]          rvfi_info,
  output logic [$clog2(DEPTH+1)-1:0] level_o,
  output logic                       overflow_o
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  typedef struct packed {
    logic [31:0]       insn;
    logic [31:0]       pc;
    logic [4:0]        rd;
    logic [INFO_W-1:0] info;
  } rec_t;

  typedef struct packed {
    logic [63:0] order;
    rec_t        rec;
    logic [31:0] wdata;
  } ent_t;

  logic [NSTAGES-1:0] valid_q, valid_d;
  rec_t               stg_q [NSTAGES];
  rec_t               stg_d [NSTAGES];
  ent_t               mem_q [DEPTH];
  ent_t               mem_d [DEPTH];
  logic [PW-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0]      cnt_q, cnt_d;
  logic [63:0]        order_q, order_d;
  logic               ovf_q, ovf_d;
  logic               retire, pop, push, full;

  // A record loading into a stage survives that stage's kill; only the old occupant is discarded.
  always_comb begin
    valid_d = valid_q;
    stg_d   = stg_q;
    if (in_valid_i) begin
      stg_d[0].insn = in_insn_i;
      stg_d[0].pc   = in_pc_rdata_i;
      stg_d[0].rd   = in_rd_addr_i;
      stg_d[0].info = in_info_i;
      valid_d[0]    = 1'b1;
    end else if (adv_i[0] | kill_i[0]) begin
      valid_d[0] = 1'b0;
    end
    for (int k = 1; k < NSTAGES; k++) begin
      if (adv_i[k-1]) begin
        stg_d[k]   = stg_q[k-1];
        valid_d[k] = valid_q[k-1] & ~kill_i[k-1];
      end else if (adv_i[k] | kill_i[k]) begin
        valid_d[k] = 1'b0;
      end
    end
  end

  assign retire = valid_q[NSTAGES-1] & adv_i[NSTAGES-1] & ~kill_i[NSTAGES-1];
  assign full   = (cnt_q == FULL_LVL);
  assign pop    = (cnt_q != '0) & rvfi_ready_i;
  assign push   = retire & (~full | pop);

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    cnt_d   = cnt_q;
    order_d = order_q;
    ovf_d   = ovf_q;
    if (push) begin
      mem_d[wptr_q].order = order_q;
      mem_d[wptr_q].rec   = stg_q[NSTAGES-1];
      mem_d[wptr_q].wdata = (stg_q[NSTAGES-1].rd == 5'd0) ? 32'd0 : rd_wdata_i;
      wptr_d              = wptr_q + PW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + PW'(1);
    end
    if (push & ~pop) begin
      cnt_d = cnt_q + LW'(1);
    end else if (pop & ~push) begin
      cnt_d = cnt_q - LW'(1);
    end
    // Dropped records still burn an order value so the consumer can see the gap.
    if (retire) begin
      order_d = order_q + 64'd1;
    end
    if (retire & ~push) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      for (int k = 0; k < NSTAGES; k++) stg_q[k] <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      order_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      stg_q   <= stg_d;
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      order_q <= order_d;
      ovf_q   <= ovf_d;
    end
  end

  assign rvfi_valid    = (cnt_q != '0);
  assign rvfi_order    = mem_q[rptr_q].order;
  assign rvfi_insn     = mem_q[rptr_q].rec.insn;
  assign rvfi_pc_rdata = mem_q[rptr_q].rec.pc;
  assign rvfi_rd_addr  = mem_q[rptr_q].rec.rd;
  assign rvfi_rd_wdata = mem_q[rptr_q].wdata;
  assign rvfi_info     = mem_q[rptr_q].rec.info;
  assign level_o       = cnt_q;
  assign overflow_o    = ovf_q;

endmodule

// File: doc/cv32e40p_rvfi_retire_buf.md
CV32E40P_RVFI_RETIRE_BUF -- requirements
Module: cv32e40p_rvfi_retire_buf

Interface
REQ-001 Parameter NSTAGES, default 3, tracked pipeline stages; legal range 2..4.
REQ-002 Parameter DEPTH, default 4, output FIFO entries; power of two, >=2.
REQ-003 Parameter INFO_W, default 8, opaque per-instruction side-band bits (trap, intr, mask, ...).
REQ-004 clk_i  in  1  single clock; all state on rising edge.
REQ-005 rst_i  in  1  reset; asynchronous assert, active-high.
REQ-006 in_valid_i  in  1  instruction leaves decode; capture into stage 0.
REQ-007 in_insn_i, in_pc_rdata_i  in  32 each  instruction word and PC, captured with in_valid_i.
REQ-008 in_rd_addr_i  in  5  destination register; 0 means no write.
REQ-009 in_info_i  in  INFO_W  side-band captured with in_valid_i.
REQ-010 adv_i  in  NSTAGES  bit k: stage k record moves on; bit NSTAGES-1 is retirement.
REQ-011 kill_i  in  NSTAGES  bit k: discard the record currently in stage k.
REQ-012 rd_wdata_i  in  32  write-back data, sampled in the retirement cycle.
REQ-013 rvfi_ready_i  in  1  consumer accepts the FIFO head.
REQ-014 rvfi_valid, rvfi_order(64), rvfi_insn(32), rvfi_pc_rdata(32), rvfi_rd_addr(5), rvfi_rd_wdata(32), rvfi_info(INFO_W)  out  FIFO head record.
REQ-015 level_o  out  $clog2(DEPTH+1)  FIFO occupancy.
REQ-016 overflow_o  out  1  sticky; a retired record was dropped.

Function
REQ-017 Each stage SHALL hold valid_q plus insn, pc_rdata, rd_addr, info; stage 0 loads when in_valid_i=1.
REQ-018 Stage k>=1 SHALL load stage k-1 contents when adv_i[k-1]=1; valid_q[k] <= valid_q[k-1] & ~kill_i[k-1].
REQ-019 Stage k not loading with adv_i[k]=1 SHALL become invalid (bubble); otherwise it holds.
REQ-020 Stage 0 with in_valid_i=0 and adv_i[0]=1 SHALL become invalid.
REQ-021 kill_i[k] SHALL invalidate only the current occupant of stage k; a record loading into k the same cycle is kept.
REQ-022 Retire event = valid_q[NSTAGES-1] & adv_i[NSTAGES-1] & ~kill_i[NSTAGES-1].
REQ-023 On retire, the record and rd_wdata_i SHALL be pushed into the FIFO with rd_wdata forced to 0 when rd_addr=0.
REQ-024 Order counter (64 bit, reset 0) SHALL be stamped onto the retired record, then increment by 1; killed records consume no order.
REQ-025 Retire when full without same-cycle pop SHALL drop the record, still consume an order value, and set overflow_o.
REQ-026 Retire and pop in the same cycle when full SHALL succeed; level_o unchanged, no overflow.
REQ-027 rvfi_valid SHALL be 1 iff level_o!=0; head pops on rvfi_valid & rvfi_ready_i; outputs stable while rvfi_valid & ~rvfi_ready_i.
REQ-028 Latency: retire in cycle t into an empty FIFO SHALL give rvfi_valid=1 in cycle t+1.
REQ-029 Pointers SHALL wrap modulo DEPTH; pop when empty SHALL be ignored.
REQ-030 Records SHALL leave the FIFO in retirement order; rvfi_order strictly increases by 1 unless a drop occurred.

Reset
REQ-031 rst_i=1 SHALL asynchronously clear all valid_q, FIFO pointers, order counter, overflow_o; level_o=0, rvfi_valid=0.
REQ-032 Data registers SHALL reset to 0; rvfi_order, rvfi_insn, rvfi_rd_wdata, rvfi_info read 0 in reset.
REQ-033 Reset asserted mid-operation SHALL discard all in-flight and buffered records; the first retirement after release gets order 0.

Verification
REQ-034 NSTAGES=3, ready=1: insn 0x00500093 (rd=1), adv all 1 for 3 cycles, rd_wdata_i=5 -> one rvfi_valid pulse, order 0, rd_wdata 5, 1 cycle after retire.
REQ-035 Back-to-back 3 instructions, second has kill_i[1] while in stage 1 -> two outputs with orders 0,1 and PCs of first and third.
REQ-036 rd_addr=0, rd_wdata_i=0xDEADBEEF -> rvfi_rd_wdata=0.
REQ-037 DEPTH=4, ready=0, retire 5 records -> level_o=4, overflow_o=1, then ready=1 drains orders 0,1,2,3.
REQ-038 FIFO full, retire and pop same cycle -> level_o stays 4, overflow_o stays 0, order continuity kept.
REQ-039 rst_i pulse with 2 records buffered and 1 in stage 1 -> rvfi_valid=0 immediately; next retirement gets order 0.
